// File: rtl/dpram_pkg.sv
// Shared constants and types for the dual-port RAM port arbiter.
// Priority encoding plus a helper that names the other client.
package dpram_pkg;

    localparam int DPRAM_DATA_W = 8;
    localparam int DPRAM_ADDR_W = 6;
    localparam int DPRAM_DEPTH  = 64;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    function automatic prio_e prio_other(input prio_e p);
        prio_e r;
        case (p)
            PRIO_A:  r = PRIO_B;
            PRIO_B:  r = PRIO_A;
            default: r = PRIO_A;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Client-side and RAM-side handshake bundle for the port arbiter.
// slave = arbiter view, master = client/RAM environment view.
interface dpram_port_arbiter_if #(
    parameter int DATA_W = dpram_pkg::DPRAM_DATA_W,
    parameter int ADDR_W = dpram_pkg::DPRAM_ADDR_W
) ();
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              ready_a;
    logic              rvalid_a;
    logic [DATA_W-1:0] rdata_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              ready_b;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata_b;

    logic              ram_we_a;
    logic              ram_we_b;
    logic [ADDR_W-1:0] ram_addr_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_data_a;
    logic [DATA_W-1:0] ram_data_b;
    logic [DATA_W-1:0] ram_q_a;
    logic [DATA_W-1:0] ram_q_b;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  ram_q_a, ram_q_b,
        output ready_a, rvalid_a, rdata_a,
        output ready_b, rvalid_b, rdata_b,
        output ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_data_a, ram_data_b
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output ram_q_a, ram_q_b,
        input  ready_a, rvalid_a, rdata_a,
        input  ready_b, rvalid_b, rdata_b,
        input  ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_data_a, ram_data_b
    );
endinterface

// File: rtl/dpram_rr_arb2.sv
// Two-way round-robin arbiter: the priority holder wins a conflict and
// the loser becomes the next priority holder.
module dpram_rr_arb2
    import dpram_pkg::*;
(
    input  logic  conflict_i,
    input  prio_e prio_i,
    input  logic  rst_i,
    output prio_e winner_o,
    output prio_e prio_d_o
);

    // Winner selection and next priority state
    always_comb begin
        winner_o = prio_i;
        prio_d_o = prio_i;
        if (rst_i) begin
            prio_d_o = PRIO_A;
        end else if (conflict_i) begin
            prio_d_o = prio_other(prio_i);
        end else begin
            prio_d_o = prio_i;
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Maps two clients onto the two ports of a dual-port RAM, serializing
// same-address accesses involving a write with round-robin priority.
module dpram_port_arbiter
    import dpram_pkg::*;
#(
    parameter int DATA_W = DPRAM_DATA_W,
    parameter int ADDR_W = DPRAM_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dpram_port_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]     conflict_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             conflict_s;
    logic             ready_a_s;
    logic             ready_b_s;
    prio_e            prio_q;
    prio_e            prio_d;
    prio_e            winner_s;
    logic             rvalid_a_q;
    logic             rvalid_a_d;
    logic             rvalid_b_q;
    logic             rvalid_b_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Same-address pair where at least one side writes
    always_comb begin
        conflict_s = bus.req_a & bus.req_b & (bus.addr_a == bus.addr_b) & (bus.we_a | bus.we_b);
    end

    dpram_rr_arb2 u_arb (
        .conflict_i (conflict_s),
        .prio_i     (prio_q),
        .rst_i      (rst),
        .winner_o   (winner_s),
        .prio_d_o   (prio_d)
    );

    // Ready gating; combinational so an unconflicted request completes in its own cycle
    always_comb begin
        ready_a_s = 1'b0;
        ready_b_s = 1'b0;
        if (rst) begin
            ready_a_s = 1'b0;
            ready_b_s = 1'b0;
        end else if (conflict_s) begin
            ready_a_s = (winner_s == PRIO_A);
            ready_b_s = (winner_s == PRIO_B);
        end else begin
            ready_a_s = bus.req_a;
            ready_b_s = bus.req_b;
        end
    end

    // Read-valid and saturating conflict counter next state
    always_comb begin
        rvalid_a_d = ready_a_s & ~bus.we_a;
        rvalid_b_d = ready_b_s & ~bus.we_b;
        cnt_d      = cnt_q;
        if (conflict_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= PRIO_A;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            prio_q     <= prio_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.ready_a    = ready_a_s;
    assign bus.ready_b    = ready_b_s;
    assign bus.ram_we_a   = ready_a_s & bus.we_a;
    assign bus.ram_we_b   = ready_b_s & bus.we_b;
    assign bus.ram_addr_a = ADDR_W'(bus.addr_a);
    assign bus.ram_addr_b = ADDR_W'(bus.addr_b);
    assign bus.ram_data_a = DATA_W'(bus.wdata_a);
    assign bus.ram_data_b = DATA_W'(bus.wdata_b);
    assign bus.rvalid_a   = rvalid_a_q;
    assign bus.rvalid_b   = rvalid_b_q;
    assign bus.rdata_a    = bus.ram_q_a;
    assign bus.rdata_b    = bus.ram_q_b;
    assign conflict_count = cnt_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench: a behavioural RAM plus a reference model of the
// arbitration rules (memory array, priority bit, saturating count).
module tb_dpram_port_arbiter;
    import dpram_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             ram_clr;
    logic [CNT_W-1:0] conflict_count;

    dpram_port_arbiter_if bus ();

    dpram_port_arbiter #(.DATA_W(8), .ADDR_W(6), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_mem [0:63];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= 8'h00;
        end else begin
            if (bus.ram_we_a) ram_mem[bus.ram_addr_a] <= bus.ram_data_a;
            if (bus.ram_we_b) ram_mem[bus.ram_addr_b] <= bus.ram_data_b;
        end
        bus.ram_q_a <= ram_mem[bus.ram_addr_a];
        bus.ram_q_b <= ram_mem[bus.ram_addr_b];
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_mem [0:63];
    bit         exp_prio;
    int         exp_cnt;
    logic       exp_rv_a, exp_rv_b;
    logic [7:0] exp_rd_a, exp_rd_b;

    function automatic bit model_conflict();
        return bus.req_a && bus.req_b && (bus.addr_a == bus.addr_b) && (bus.we_a || bus.we_b);
    endfunction

    function automatic void model_ready(output logic ea, output logic eb);
        if (rst) begin
            ea = 1'b0; eb = 1'b0;
        end else if (model_conflict()) begin
            ea = (exp_prio == 1'b0);
            eb = (exp_prio == 1'b1);
        end else begin
            ea = bus.req_a; eb = bus.req_b;
        end
    endfunction

    task automatic tick();
        logic ea, eb;
        logic [7:0] old_a, old_b;
        bit conf;
        model_ready(ea, eb);
        conf  = model_conflict();
        old_a = exp_mem[bus.addr_a];
        old_b = exp_mem[bus.addr_b];
        if (rst) begin
            exp_prio = 1'b0; exp_cnt = 0; exp_rv_a = 1'b0; exp_rv_b = 1'b0;
        end else begin
            if (ea && bus.we_a) exp_mem[bus.addr_a] = bus.wdata_a;
            if (eb && bus.we_b) exp_mem[bus.addr_b] = bus.wdata_b;
            exp_rv_a = ea && !bus.we_a;
            exp_rv_b = eb && !bus.we_b;
            exp_rd_a = old_a;
            exp_rd_b = old_b;
            if (conf) begin
                exp_prio = ea ? 1'b1 : 1'b0;
                if (exp_cnt < CNT_MAX) exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
        bus.req_a = r; bus.we_a = w; bus.addr_a = a; bus.wdata_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
        bus.req_b = r; bus.we_b = w; bus.addr_b = a; bus.wdata_b = d;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 6'd0, 8'h00);
        set_b(1'b0, 1'b0, 6'd0, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1; ram_clr = 1'b1;
        set_a(1'b1, 1'b1, 6'd5, 8'h12);
        set_b(1'b1, 1'b1, 6'd5, 8'h34);
        #1;
        checks++; if (bus.ready_a !== 1'b0 || bus.ready_b !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b exp 00", bus.ready_a, bus.ready_b); end
        checks++; if (bus.ram_we_a !== 1'b0 || bus.ram_we_b !== 1'b0) begin errors++; $display("FAIL reset_we: got %b%b exp 00", bus.ram_we_a, bus.ram_we_b); end
        tick(); tick();
        ram_clr = 1'b0;
        checks++; if (bus.rvalid_a !== 1'b0 || bus.rvalid_b !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b exp 00", bus.rvalid_a, bus.rvalid_b); end
        checks++; if (conflict_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", conflict_count); end
        rst = 1'b0; idle();
    endtask

    task automatic test_write_read();
        set_a(1'b1, 1'b1, 6'd10, 8'hAA); #1;
        checks++; if (bus.ready_a !== 1'b1 || bus.ram_we_a !== 1'b1) begin errors++; $display("FAIL wr_accept: got rdy=%b we=%b exp 1 1", bus.ready_a, bus.ram_we_a); end
        tick(); idle();
        set_b(1'b1, 1'b0, 6'd10, 8'h00); #1;
        checks++; if (bus.ready_b !== 1'b1 || bus.ram_we_b !== 1'b0) begin errors++; $display("FAIL rd_accept: got rdy=%b we=%b exp 1 0", bus.ready_b, bus.ram_we_b); end
        tick(); idle(); #1;
        checks++; if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== 8'hAA) begin errors++; $display("FAIL raw_read: got v=%b d=%h exp 1 aa", bus.rvalid_b, bus.rdata_b); end
        checks++; if (conflict_count !== 4'd0) begin errors++; $display("FAIL raw_count: got %0d exp 0", conflict_count); end
        tick();
        checks++; if (bus.rvalid_b !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b exp 0", bus.rvalid_b); end
    endtask

    task automatic test_write_collision();
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        set_a(1'b1, 1'b1, 6'd15, 8'hF0);
        set_b(1'b1, 1'b1, 6'd15, 8'h0F); #1;
        checks++; if (bus.ready_a !== 1'b1 || bus.ready_b !== 1'b0 || bus.ram_we_b !== 1'b0) begin errors++; $display("FAIL ww_cycle0: got a=%b b=%b web=%b exp 1 0 0", bus.ready_a, bus.ready_b, bus.ram_we_b); end
        tick();
        set_a(1'b0, 1'b0, 6'd0, 8'h00); #1;
        checks++; if (bus.ready_b !== 1'b1 || bus.ram_we_b !== 1'b1) begin errors++; $display("FAIL ww_cycle1: got b=%b web=%b exp 1 1", bus.ready_b, bus.ram_we_b); end
        tick(); idle();
        set_a(1'b1, 1'b0, 6'd15, 8'h00); #1;
        tick(); idle(); #1;
        checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'h0F) begin errors++; $display("FAIL ww_result: got v=%b d=%h exp 1 0f", bus.rvalid_a, bus.rdata_a); end
        checks++; if (conflict_count !== 4'd1) begin errors++; $display("FAIL ww_count: got %0d exp 1", conflict_count); end
    endtask

    task automatic test_same_reads();
        set_a(1'b1, 1'b0, 6'd10, 8'h00);
        set_b(1'b1, 1'b0, 6'd10, 8'h00); #1;
        checks++; if (bus.ready_a !== 1'b1 || bus.ready_b !== 1'b1) begin errors++; $display("FAIL rr_ready: got %b%b exp 11", bus.ready_a, bus.ready_b); end
        tick(); idle(); #1;
        checks++; if (bus.rvalid_a !== 1'b1 || bus.rvalid_b !== 1'b1 || bus.rdata_a !== 8'hAA || bus.rdata_b !== 8'hAA) begin errors++; $display("FAIL rr_data: got %b%b %h %h exp 11 aa aa", bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b); end
        checks++; if (conflict_count !== 4'd1) begin errors++; $display("FAIL rr_count: got %0d exp 1", conflict_count); end
    endtask

    task automatic test_write_read_conflict();
        set_a(1'b1, 1'b1, 6'd20, 8'h55); #1; tick(); idle();
        set_a(1'b1, 1'b1, 6'd20, 8'h11);
        set_b(1'b1, 1'b0, 6'd20, 8'h00); #1;
        checks++; if (bus.ready_b !== 1'b1 || bus.ready_a !== 1'b0 || bus.ram_we_a !== 1'b0) begin errors++; $display("FAIL wr_prio_b: got b=%b a=%b wea=%b exp 1 0 0", bus.ready_b, bus.ready_a, bus.ram_we_a); end
        tick();
        set_b(1'b0, 1'b0, 6'd0, 8'h00); #1;
        checks++; if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== 8'h55) begin errors++; $display("FAIL wr_old_data: got v=%b d=%h exp 1 55", bus.rvalid_b, bus.rdata_b); end
        checks++; if (bus.ready_a !== 1'b1 || bus.ram_we_a !== 1'b1) begin errors++; $display("FAIL wr_late_write: got a=%b wea=%b exp 1 1", bus.ready_a, bus.ram_we_a); end
        tick(); idle();
        set_b(1'b1, 1'b0, 6'd20, 8'h00); #1; tick(); idle(); #1;
        checks++; if (bus.rdata_b !== 8'h11) begin errors++; $display("FAIL wr_new_data: got %h exp 11", bus.rdata_b); end
    endtask

    task automatic test_fairness();
        logic [7:0] da, db;
        logic ea, eb;
        da = 8'h30; db = 8'h80;
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 1'b1, 6'd3, da);
            set_b(1'b1, 1'b1, 6'd3, db); #1;
            model_ready(ea, eb);
            checks++; if (bus.ready_a !== ((i % 2) == 0) || bus.ready_b !== ((i % 2) == 1)) begin errors++; $display("FAIL fair_alt%0d: got a=%b b=%b exp a=%b", i, bus.ready_a, bus.ready_b, (i % 2) == 0); end
            checks++; if (bus.ready_a !== ea || bus.ready_b !== eb) begin errors++; $display("FAIL fair_model%0d: got %b%b exp %b%b", i, bus.ready_a, bus.ready_b, ea, eb); end
            if (ea) da = da + 8'd1;
            if (eb) db = db + 8'd1;
            tick();
        end
        idle();
        checks++; if (conflict_count !== 4'(exp_cnt)) begin errors++; $display("FAIL fair_count: got %0d exp %0d", conflict_count, exp_cnt); end
    endtask

    task automatic test_random();
        bit pa, pb;
        logic ea, eb;
        pa = 1'b0; pb = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!pa && ($urandom_range(0, 9) < 6)) begin
                set_a(1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 8'($urandom));
                pa = 1'b1;
            end else if (!pa) begin
                bus.req_a = 1'b0;
            end
            if (!pb && ($urandom_range(0, 9) < 6)) begin
                set_b(1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 8'($urandom));
                pb = 1'b1;
            end else if (!pb) begin
                bus.req_b = 1'b0;
            end
            #1;
            model_ready(ea, eb);
            checks++; if (bus.ready_a !== ea || bus.ready_b !== eb) begin errors++; $display("FAIL rnd_ready%0d: got %b%b exp %b%b", n, bus.ready_a, bus.ready_b, ea, eb); end
            checks++; if (bus.ram_we_a !== (ea & bus.we_a) || bus.ram_we_b !== (eb & bus.we_b)) begin errors++; $display("FAIL rnd_we%0d: got %b%b", n, bus.ram_we_a, bus.ram_we_b); end
            tick();
            if (ea) pa = 1'b0;
            if (eb) pb = 1'b0;
            checks++; if (bus.rvalid_a !== exp_rv_a || bus.rvalid_b !== exp_rv_b) begin errors++; $display("FAIL rnd_rvalid%0d: got %b%b exp %b%b", n, bus.rvalid_a, bus.rvalid_b, exp_rv_a, exp_rv_b); end
            if (exp_rv_a) begin
                checks++; if (bus.rdata_a !== exp_rd_a) begin errors++; $display("FAIL rnd_rdata_a%0d: got %h exp %h", n, bus.rdata_a, exp_rd_a); end
            end
            if (exp_rv_b) begin
                checks++; if (bus.rdata_b !== exp_rd_b) begin errors++; $display("FAIL rnd_rdata_b%0d: got %h exp %h", n, bus.rdata_b, exp_rd_b); end
            end
            checks++; if (conflict_count !== 4'(exp_cnt)) begin errors++; $display("FAIL rnd_count%0d: got %0d exp %0d", n, conflict_count, exp_cnt); end
        end
        idle();
    endtask

    task automatic test_saturation_reset();
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_a(1'b1, 1'b1, 6'd7, 8'(i));
            set_b(1'b1, 1'b1, 6'd7, 8'(i + 100));
            #1; tick();
        end
        checks++; if (conflict_count !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d exp 15", conflict_count); end
        set_a(1'b1, 1'b1, 6'd9, 8'hF0);
        set_b(1'b1, 1'b1, 6'd9, 8'h0F); #1; tick();
        checks++; if (conflict_count !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d exp 15", conflict_count); end
        rst = 1'b1;
        set_a(1'b1, 1'b0, 6'd9, 8'h00); #1;
        checks++; if (bus.ready_a !== 1'b0 || bus.ready_b !== 1'b0 || bus.ram_we_b !== 1'b0) begin errors++; $display("FAIL rst_stall_ready: got %b%b web=%b exp 00 0", bus.ready_a, bus.ready_b, bus.ram_we_b); end
        tick();
        rst = 1'b0; idle(); #1;
        checks++; if (bus.rvalid_a !== 1'b0 || bus.rvalid_b !== 1'b0 || conflict_count !== 4'd0) begin errors++; $display("FAIL rst_stall_state: got v=%b%b cnt=%0d exp 00 0", bus.rvalid_a, bus.rvalid_b, conflict_count); end
        checks++; if (ram_mem[9] !== 8'hF0) begin errors++; $display("FAIL rst_no_write: got %h exp f0", ram_mem[9]); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
        exp_prio = 1'b0; exp_cnt = 0; exp_rv_a = 1'b0; exp_rv_b = 1'b0;
        exp_rd_a = 8'h00; exp_rd_b = 8'h00;
        test_reset();
        test_write_read();
        test_write_collision();
        test_same_reads();
        test_write_read_conflict();
        test_fairness();
        test_random();
        test_saturation_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
